param_shift_register: RTL and testbench

- Parametrised next-generation general-purpose datapath register, WIDTH bits wide.
- Keeps the single-cycle clear/load/inc/dec/shift-by-one operations of the existing 4-bit register.
- Adds: selectable shift modes (logical, arithmetic, rotate, serial-fill); a multi-cycle shift-by-N engine with busy/done handshake; carry and zero flags.
- Sits beside the ALU as an accumulator/shift unit for the CPU datapath.

---
 rtl/param_shift_register_pkg.sv | 15 +
 rtl/param_shift_register_shift_step.sv | 40 ++++
 rtl/param_shift_register.sv | 141 ++++++++++++++
 tb/tb_param_shift_register.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/param_shift_register_pkg.sv
// Shared encodings for the parametrised shift/accumulator register.
package param_shift_register_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

endpackage

// File: rtl/param_shift_register_shift_step.sv
// One-position shift in either direction; the mode selects which bit enters the vacated end.
module shift_step
  import param_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] next_value,
  output logic             shifted_out
);

  logic fill_bit;

  always_comb begin
    fill_bit = 1'b0;
    if (dir == DIR_R) begin
      shifted_out = value[0];
      unique case (mode)
        MODE_LOG: fill_bit = 1'b0;
        MODE_ARI: fill_bit = value[WIDTH-1];
        MODE_ROT: fill_bit = value[0];
        MODE_SER: fill_bit = fill;
        default:  fill_bit = 1'b0;
      endcase
      next_value = {fill_bit, value[WIDTH-1:1]};
    end else begin
      shifted_out = value[WIDTH-1];
      unique case (mode)
        MODE_ROT: fill_bit = value[WIDTH-1];
        MODE_SER: fill_bit = fill;
        default:  fill_bit = 1'b0;
      endcase
      next_value = {value[WIDTH-2:0], fill_bit};
    end
  end

endmodule

// File: rtl/param_shift_register.sv
// Datapath register: single-cycle clear/load/inc/dec/shift plus a multi-cycle shift-by-N engine.
module param_shift_register
  import param_shift_register_pkg::*;
#(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  localparam int unsigned          AW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             ir,
  input  logic             sl,
  input  logic             il,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             dir,
  input  logic [AW-1:0]    shamt,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] WidthAw = AW'(WIDTH);

  logic             state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [AW-1:0]    shamt_clamped;
  logic             step_dir;
  logic [1:0]       step_mode;
  logic [WIDTH-1:0] step_value;
  logic             step_out;

  assign shamt_clamped = (shamt > WidthAw) ? WidthAw : shamt;

  // The engine uses its latched dir/mode; single steps use live inputs (sr beats sl).
  assign step_dir  = (state_q == ST_SHIFT) ? dir_q : (sr ? DIR_R : DIR_L);
  assign step_mode = (state_q == ST_SHIFT) ? mode_q : mode;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .value       (out_q),
    .dir         (step_dir),
    .mode        (step_mode),
    .fill        ((step_dir == DIR_R) ? ir : il),
    .next_value  (step_value),
    .shifted_out (step_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    out_d   = out_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (cl) begin
        out_d   = '0;
        carry_d = 1'b0;
      end else if (ld) begin
        out_d   = in;
        carry_d = 1'b0;
      end else if (start) begin
        if (shamt_clamped == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_SHIFT;
          cnt_d   = shamt_clamped;
          dir_d   = dir;
          mode_d  = mode;
        end
      end else if (inc) begin
        out_d   = out_q + 1'b1;
        carry_d = &out_q;
      end else if (dec) begin
        out_d   = out_q - 1'b1;
        carry_d = (out_q == '0);
      end else if (sr || sl) begin
        out_d   = step_value;
        carry_d = step_out;
      end
    end else begin
      if (cl) begin
        out_d   = '0;
        carry_d = 1'b0;
        state_d = ST_IDLE;
      end else begin
        out_d   = step_value;
        carry_d = step_out;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == AW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      mode_q  <= MODE_LOG;
      out_q   <= RESET_VAL;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = (out_q == '0);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register at WIDTH=8.
module tb_param_shift_register;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             cl, ld, inc, dec, sr, ir, sl, il, start, dir;
  logic [WIDTH-1:0] in;
  logic [1:0]       mode;
  logic [AW-1:0]    shamt;
  logic [WIDTH-1:0] out;
  logic             carry, zero, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  param_shift_register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cl    (cl),
    .ld    (ld),
    .in    (in),
    .inc   (inc),
    .dec   (dec),
    .sr    (sr),
    .ir    (ir),
    .sl    (sl),
    .il    (il),
    .mode  (mode),
    .start (start),
    .dir   (dir),
    .shamt (shamt),
    .out   (out),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs are then driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt, done_cnt;
  logic [WIDTH-1:0] out_at_done;

  initial begin
    rst_n = 1'b0; cl = 0; ld = 1; in = 8'h5A; inc = 0; dec = 0;
    sr = 0; ir = 0; sl = 0; il = 0; mode = 2'b00; start = 0; dir = 0; shamt = '0;

    // Reset overrides a pending load
    step();
    check_eq("rst_out", 32'(out), 32'h00);
    check_eq("rst_carry", 32'(carry), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);

    rst_n = 1; ld = 1; in = 8'hFF;
    step();
    check_eq("ld_ff", 32'(out), 32'hFF);
    ld = 0;
    rst_n = 0;
    #3;
    check_eq("rst_between_edges", 32'(out), 32'hFF);
    step();
    check_eq("rst_at_edge", 32'(out), 32'h00);
    rst_n = 1;

    // Wrap-around
    ld = 1; in = 8'hFF; step();
    ld = 0; inc = 1; step();
    check_eq("inc_wrap_out", 32'(out), 32'h00);
    check_eq("inc_wrap_carry", 32'(carry), 1);
    check_eq("inc_wrap_zero", 32'(zero), 1);
    inc = 0; dec = 1; step();
    check_eq("dec_wrap_out", 32'(out), 32'hFF);
    check_eq("dec_wrap_carry", 32'(carry), 1);
    check_eq("dec_wrap_zero", 32'(zero), 0);
    inc = 1; dec = 1; step();
    check_eq("inc_over_dec", 32'(out), 32'h00);
    inc = 0; dec = 0;

    // Arithmetic right by 3
    ld = 1; in = 8'h96; step();
    ld = 0; mode = 2'b01; dir = 0; shamt = 4'd3; start = 1; step();
    start = 0; mode = 2'b00; dir = 1;
    check_eq("ari_start_busy", 32'(busy), 1);
    check_eq("ari_start_out", 32'(out), 32'h96);
    step();
    check_eq("ari_s1", 32'(out), 32'hCB);
    check_eq("ari_s1_carry", 32'(carry), 0);
    check_eq("ari_s1_done", 32'(done), 0);
    step();
    check_eq("ari_s2", 32'(out), 32'hE5);
    check_eq("ari_s2_busy", 32'(busy), 1);
    step();
    check_eq("ari_s3", 32'(out), 32'hF2);
    check_eq("ari_done", 32'(done), 1);
    check_eq("ari_busy_end", 32'(busy), 0);
    check_eq("ari_carry", 32'(carry), 1);
    step();
    check_eq("ari_done_pulse", 32'(done), 0);

    // Rotate left, shamt clamped from 9 to 8
    ld = 1; in = 8'h81; step();
    ld = 0; mode = 2'b10; dir = 1; shamt = 4'd9; start = 1; step();
    start = 0;
    busy_cnt = 0; done_cnt = 0; out_at_done = '0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        out_at_done = out;
      end
      step();
    end
    check_eq("rot_busy_cycles", 32'(busy_cnt), 8);
    check_eq("rot_done_pulses", 32'(done_cnt), 1);
    check_eq("rot_out", 32'(out_at_done), 32'h81);
    check_eq("rot_carry", 32'(carry), 1);
    shamt = 4'd0; start = 1; step();
    start = 0;
    check_eq("n0_busy", 32'(busy), 0);
    check_eq("n0_done", 32'(done), 1);
    check_eq("n0_out", 32'(out), 32'h81);
    step();
    check_eq("n0_done_pulse", 32'(done), 0);

    // Loads ignored mid-shift, clear aborts without done
    mode = 2'b00; dir = 0; shamt = 4'd5; start = 1; step();
    start = 0; ld = 1; in = 8'h33; step();
    check_eq("ign_ld_out", 32'(out), 32'h40);
    check_eq("ign_ld_busy", 32'(busy), 1);
    ld = 0; cl = 1; step();
    cl = 0;
    check_eq("cl_abort_out", 32'(out), 32'h00);
    check_eq("cl_abort_busy", 32'(busy), 0);
    check_eq("cl_abort_done", 32'(done), 0);
    step();
    check_eq("cl_abort_nodone", 32'(done), 0);

    // Reset mid-shift
    ld = 1; in = 8'hF0; step();
    ld = 0; shamt = 4'd4; start = 1; step();
    start = 0; step();
    check_eq("pre_rst_out", 32'(out), 32'h78);
    rst_n = 0; step();
    check_eq("rst_mid_out", 32'(out), 32'h00);
    check_eq("rst_mid_busy", 32'(busy), 0);
    check_eq("rst_mid_done", 32'(done), 0);
    rst_n = 1; step();
    check_eq("rst_mid_nodone", 32'(done), 0);
    check_eq("rst_mid_idle", 32'(busy), 0);

    // Priority and serial fill
    cl = 1; ld = 1; in = 8'h77; step();
    check_eq("cl_over_ld", 32'(out), 32'h00);
    cl = 0; ld = 1; inc = 1; in = 8'h10; step();
    check_eq("ld_over_inc", 32'(out), 32'h10);
    ld = 0; inc = 0; mode = 2'b11; sr = 1; ir = 1; step();
    check_eq("ser_sr_out", 32'(out), 32'h88);
    check_eq("ser_sr_carry", 32'(carry), 0);
    sr = 0; ir = 0; sl = 1; il = 1; step();
    check_eq("ser_sl_out", 32'(out), 32'h11);
    check_eq("ser_sl_carry", 32'(carry), 1);
    sl = 0; il = 0; step();
    check_eq("hold_out", 32'(out), 32'h11);
    check_eq("hold_carry", 32'(carry), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
